// File: rtl/ysyx_23060072_pkg.sv
// Shared definitions for the RV32E pipeline registers: widths, ALU opcodes
// and the ID/EX payload layout consumed by the forwarding unit and EX stage.
package ysyx_23060072_pkg;

    localparam int XLEN    = 32;
    localparam int RAW     = 5;
    localparam int ALUOP_W = 5;

    // ALU operation encodings produced by ID and carried through ID/EX
    localparam logic [ALUOP_W-1:0] ALU_ADD  = 5'd0;
    localparam logic [ALUOP_W-1:0] ALU_SUB  = 5'd1;
    localparam logic [ALUOP_W-1:0] ALU_AND  = 5'd2;
    localparam logic [ALUOP_W-1:0] ALU_OR   = 5'd3;
    localparam logic [ALUOP_W-1:0] ALU_XOR  = 5'd4;
    localparam logic [ALUOP_W-1:0] ALU_SLL  = 5'd5;
    localparam logic [ALUOP_W-1:0] ALU_SRL  = 5'd6;
    localparam logic [ALUOP_W-1:0] ALU_SRA  = 5'd7;
    localparam logic [ALUOP_W-1:0] ALU_SLT  = 5'd8;
    localparam logic [ALUOP_W-1:0] ALU_SLTU = 5'd9;

    // Control flags: these are what must vanish on a flush or bubble so the
    // forwarding unit never matches against a dead instruction.
    typedef struct packed {
        logic has_rs1;
        logic has_rs2;
        logic wb_flag;
        logic load_flag;
        logic store_flag;
    } id2ex_flags_t;

    // Data fields: allowed to hold stale values while the stage is empty.
    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [RAW-1:0]     rs1_addr;
        logic [RAW-1:0]     rs2_addr;
        logic [RAW-1:0]     wb_addr;
        logic [XLEN-1:0]    operand_a;
        logic [XLEN-1:0]    operand_b;
        logic [ALUOP_W-1:0] alu_op;
    } id2ex_data_t;

    // Complete ID/EX payload
    typedef struct packed {
        id2ex_flags_t flags;
        id2ex_data_t  data;
    } id2ex_t;

    localparam int FLAGS_W = $bits(id2ex_flags_t);
    localparam int DATA_W  = $bits(id2ex_data_t);

endpackage

// File: rtl/ysyx_23060072_pipe_reg.sv
// Generic pipeline payload register. Priority: rst > clear > load > hold.
// Shared by the ID/EX, EX/LSU and LSU/WB stage registers.
module ysyx_23060072_pipe_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;
    logic [W-1:0] q_next;

    // Next-state selection; holding is the default
    always_comb begin
        q_next = q_reg;
        if (clear) begin
            q_next = '0;
        end else if (load) begin
            q_next = d;
        end
    end

    // Payload flops with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/ysyx_23060072_id2ex.sv
// ID/EX pipeline register of the RV32E core. Captures the decoded
// instruction, stalls for load-use and EX backpressure, squashes on a
// redirect, and counts load-use stall cycles.
module ysyx_23060072_id2ex
    import ysyx_23060072_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    output logic               id_ready,
    input  logic [XLEN-1:0]    id_pc,
    input  logic               id_has_rs1,
    input  logic               id_has_rs2,
    input  logic [RAW-1:0]     id_rs1_addr,
    input  logic [RAW-1:0]     id_rs2_addr,
    input  logic [XLEN-1:0]    id_operand_a,
    input  logic [XLEN-1:0]    id_operand_b,
    input  logic               id_wb_flag,
    input  logic               id_load_flag,
    input  logic               id_store_flag,
    input  logic [RAW-1:0]     id_wb_addr,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic               load_use,
    input  logic               flush,
    input  logic               ex_ready,
    output logic               ex_valid,
    output logic [XLEN-1:0]    id2ex_pc,
    output logic               id2ex_has_rs1,
    output logic               id2ex_has_rs2,
    output logic               id2ex_store_flag,
    output logic               id2ex_load_flag,
    output logic               id2ex_wb_flag,
    output logic [RAW-1:0]     id2ex_rs1_addr,
    output logic [RAW-1:0]     id2ex_rs2_addr,
    output logic [RAW-1:0]     id2ex_wb_addr,
    output logic [XLEN-1:0]    id2ex_operand_a,
    output logic [XLEN-1:0]    id2ex_operand_b,
    output logic [ALUOP_W-1:0] id2ex_alu_op,
    output logic [CNT_W-1:0]   stall_cnt
);

    id2ex_t               id_payload;
    id2ex_flags_t         flags_reg;
    id2ex_flags_t         flags_out;
    id2ex_data_t          data_reg;
    logic                 valid_reg;
    logic                 hold;
    logic                 ctl_load;
    logic                 ctl_clear;
    logic [CNT_W-1:0]     stall_cnt_reg;
    logic [CNT_W-1:0]     stall_cnt_next;

    // Pack the ID-side fields into the stage payload
    always_comb begin
        id_payload                 = '0;
        id_payload.flags.has_rs1    = id_has_rs1;
        id_payload.flags.has_rs2    = id_has_rs2;
        id_payload.flags.wb_flag    = id_wb_flag;
        id_payload.flags.load_flag  = id_load_flag;
        id_payload.flags.store_flag = id_store_flag;
        id_payload.data.pc          = id_pc;
        id_payload.data.rs1_addr    = id_rs1_addr;
        id_payload.data.rs2_addr    = id_rs2_addr;
        id_payload.data.wb_addr     = id_wb_addr;
        id_payload.data.operand_a   = id_operand_a;
        id_payload.data.operand_b   = id_operand_b;
        id_payload.data.alu_op      = id_alu_op;
    end

    // A live instruction stays put while load-use is pending or EX is busy;
    // an empty stage never holds, so a stray load_use there is ignored.
    assign hold     = valid_reg & (load_use | ~ex_ready);
    assign id_ready = ~hold | flush;
    assign ex_valid = valid_reg & ~load_use;

    // Stage control: flush beats hold, hold beats capture, else bubble
    always_comb begin
        ctl_load  = 1'b0;
        ctl_clear = 1'b0;
        if (flush) begin
            ctl_clear = 1'b1;
        end else if (!hold) begin
            if (id_valid) begin
                ctl_load = 1'b1;
            end else begin
                ctl_clear = 1'b1;
            end
        end
    end

    // Valid bit travels with the flags so both clear together
    ysyx_23060072_pipe_reg #(
        .W (1 + FLAGS_W)
    ) u_ctl_reg (
        .clk   (clk),
        .rst   (rst),
        .load  (ctl_load),
        .clear (ctl_clear),
        .d     ({1'b1, id_payload.flags}),
        .q     ({valid_reg, flags_reg})
    );

    // Data fields are only ever loaded; stale values are harmless once the
    // flags are zero
    ysyx_23060072_pipe_reg #(
        .W (DATA_W)
    ) u_data_reg (
        .clk   (clk),
        .rst   (rst),
        .load  (ctl_load),
        .clear (1'b0),
        .d     (id_payload.data),
        .q     (data_reg)
    );

    // Flags are qualified by the valid bit so an empty stage never looks
    // like a producer to the forwarding unit
    generate
        for (genvar gi = 0; gi < FLAGS_W; gi++) begin : g_flag_gate
            assign flags_out[gi] = flags_reg[gi] & valid_reg;
        end
    endgenerate

    // Saturating load-use stall counter
    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (valid_reg && load_use && !flush && !(&stall_cnt_reg)) begin
            stall_cnt_next = stall_cnt_reg + 1'b1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign stall_cnt        = stall_cnt_reg;
    assign id2ex_has_rs1    = flags_out.has_rs1;
    assign id2ex_has_rs2    = flags_out.has_rs2;
    assign id2ex_wb_flag    = flags_out.wb_flag;
    assign id2ex_load_flag  = flags_out.load_flag;
    assign id2ex_store_flag = flags_out.store_flag;
    assign id2ex_pc         = data_reg.pc;
    assign id2ex_rs1_addr   = data_reg.rs1_addr;
    assign id2ex_rs2_addr   = data_reg.rs2_addr;
    assign id2ex_wb_addr    = data_reg.wb_addr;
    assign id2ex_operand_a  = data_reg.operand_a;
    assign id2ex_operand_b  = data_reg.operand_b;
    assign id2ex_alu_op     = data_reg.alu_op;

endmodule
